systolic_skew_feeder: RTL

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

---
 rtl/systolic_skew_feeder_pkg.sv | 39 +++
 rtl/systolic_skew_feeder_if.sv | 27 ++
 rtl/fp32_regfile9.sv | 26 ++
 rtl/systolic_skew_feeder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants, state encoding and skew helper for the systolic operand feeder.
// Matrices are stored row-major, nine FP32 words per matrix.
package systolic_skew_feeder_pkg;

    localparam int SYS_N      = 3;
    localparam int FP_W       = 32;
    localparam int FEED_STEPS = 2 * SYS_N - 1;
    localparam int NUM_ELEM   = SYS_N * SYS_N;
    localparam int IDX_W      = 4;
    localparam int STEP_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_e;

    typedef logic [NUM_ELEM-1:0][FP_W-1:0] mat_t;
    typedef logic [SYS_N-1:0][FP_W-1:0]    lane_t;

    // Element entering lane `lane` at step `step`: west lanes walk along row `lane`,
    // north lanes walk down column `lane`. Outside the 3-wide window the lane is zero.
    function automatic logic [FP_W-1:0] skew_pick(input mat_t       m,
                                                  input logic [STEP_W-1:0] step,
                                                  input int         lane,
                                                  input logic       col_walk);
        int         d;
        logic [3:0] k;
        skew_pick = '0;
        k         = '0;
        d         = int'(step) - lane;
        if (d >= 0 && d < SYS_N) begin
            k         = col_walk ? 4'(d * SYS_N + lane) : 4'(lane * SYS_N + d);
            skew_pick = m[k];
        end
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Operand write port of the skew feeder: one FP32 word into A or B per handshake.
interface systolic_skew_feeder_if;
    import systolic_skew_feeder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [IDX_W-1:0] in_idx;
    logic [FP_W-1:0]  in_data;

    modport master (
        output in_valid,
        output in_sel,
        output in_idx,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_sel,
        input  in_idx,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/fp32_regfile9.sv
// Nine-entry FP32 register file: one write port, all entries readable combinationally.
// Out-of-range write addresses are dropped so stray indices cannot alias real entries.
module fp32_regfile9
    import systolic_skew_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [FP_W-1:0]  wdata,
    output mat_t             rdata
);

    mat_t mem;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem <= '0;
        end else if (we && (waddr < 4'(NUM_ELEM))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem;

endmodule

// File: rtl/systolic_skew_feeder.sv
// Loads 3x3 A/B operand matrices, then streams them diagonally skewed into a
// systolic array's west/north edges, followed by a zero drain and a done pulse.
//
// state    | meaning
// ---------|------------------------------------------------------------
// ST_IDLE  | accepting operand writes, waiting for start
// ST_FEED  | five skewed steps on W/N lanes, feed_valid high
// ST_DRAIN | DRAIN_CYCLES all-zero cycles to flush the array
// ST_DONE  | single-cycle done pulse, then back to IDLE
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    systolic_skew_feeder_if.slave  wr,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   feed_valid,
    output logic [FP_W-1:0]        W0,
    output logic [FP_W-1:0]        W1,
    output logic [FP_W-1:0]        W2,
    output logic [FP_W-1:0]        N0,
    output logic [FP_W-1:0]        N1,
    output logic [FP_W-1:0]        N2
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    feed_state_e         state, state_next;
    logic [STEP_W-1:0]   step, step_next;
    logic [DRAIN_W-1:0]  drain_cnt, drain_next;

    logic  wr_fire, a_we, b_we, idx_ok;
    mat_t  a_q, b_q, a_view, b_view;
    lane_t w_pick, n_pick, w_q, n_q;

    assign wr.in_ready = (state == ST_IDLE);
    assign wr_fire     = wr.in_valid && wr.in_ready;
    assign a_we        = wr_fire && !wr.in_sel;
    assign b_we        = wr_fire &&  wr.in_sel;
    assign idx_ok      = (wr.in_idx < 4'(NUM_ELEM));

    fp32_regfile9 u_mat_a (
        .clk   (clk),
        .reset (reset),
        .we    (a_we),
        .waddr (wr.in_idx),
        .wdata (wr.in_data),
        .rdata (a_q)
    );

    fp32_regfile9 u_mat_b (
        .clk   (clk),
        .reset (reset),
        .we    (b_we),
        .waddr (wr.in_idx),
        .wdata (wr.in_data),
        .rdata (b_q)
    );

    // Forward a write landing in the start cycle so step 0 already sees it.
    always_comb begin
        a_view = a_q;
        b_view = b_q;
        if (a_we && idx_ok) a_view[wr.in_idx] = wr.in_data;
        if (b_we && idx_ok) b_view[wr.in_idx] = wr.in_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            step      <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            step      <= step_next;
            drain_cnt <= drain_next;
        end
    end

    always_comb begin
        state_next = state;
        step_next  = step;
        drain_next = drain_cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FEED;
                    step_next  = '0;
                end
            end
            ST_FEED: begin
                if (step == STEP_W'(FEED_STEPS - 1)) begin
                    step_next = '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_DRAIN;
                        drain_next = DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end else begin
                    step_next = step + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) state_next = ST_DONE;
                else                 drain_next = drain_cnt - 1'b1;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < SYS_N; gi++) begin : g_lane
        assign w_pick[gi] = skew_pick(a_view, step_next, gi, 1'b0);
        assign n_pick[gi] = skew_pick(b_view, step_next, gi, 1'b1);
    end

    // Lanes are loaded with the value for the state being entered, keeping them registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_q <= '0;
            n_q <= '0;
        end else if (state_next == ST_FEED) begin
            w_q <= w_pick;
            n_q <= n_pick;
        end else begin
            w_q <= '0;
            n_q <= '0;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign feed_valid = (state == ST_FEED);

    assign W0 = w_q[0];
    assign W1 = w_q[1];
    assign W2 = w_q[2];
    assign N0 = n_q[0];
    assign N1 = n_q[1];
    assign N2 = n_q[2];

endmodule
